// File: rtl/fifo_wr_arbiter_if.sv
// Requester/FIFO write-port bundle for fifo_wr_arbiter.
// master = requesters + FIFO side, slave = the arbiter.
interface fifo_wr_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 2
);
  logic [NUM_REQ-1:0]            i_req_valid;
  logic [NUM_REQ*DATA_WIDTH-1:0] i_req_data;
  logic [NUM_REQ-1:0]            i_req_last;
  logic [NUM_REQ-1:0]            o_req_ready;
  logic [NUM_REQ-1:0]            o_grant;
  logic                          o_busy;
  logic                          o_fifo_wr;
  logic [DATA_WIDTH-1:0]         o_fifo_wdata;
  logic                          i_fifo_wfull;

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_fifo_wfull,
    input  o_req_ready, o_grant, o_busy, o_fifo_wr, o_fifo_wdata
  );

  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_fifo_wfull,
    output o_req_ready, o_grant, o_busy, o_fifo_wr, o_fifo_wdata
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter sharing one async-FIFO write port among NUM_REQ requesters.
// Optional per-requester beat statistics: define FIFO_ARB_STATS_EN.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 2,
  parameter int MAX_BURST  = 4,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         i_wclk,
  input  logic                         i_rrstn,
  fifo_wr_arbiter_if.slave             bus
`ifdef FIFO_ARB_STATS_EN
  ,
  output logic [NUM_REQ*CNT_WIDTH-1:0] o_beat_cnt
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BC_W  = $clog2(MAX_BURST + 1);

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] grant_q;
  logic [IDX_W-1:0]   gidx_q;
  logic [IDX_W-1:0]   ptr_q;
  logic [BC_W-1:0]    bcnt_q;

  logic                  pick_vld;
  logic [IDX_W-1:0]      pick_idx;
  logic                  busy;
  logic                  g_valid;
  logic                  g_last;
  logic [DATA_WIDTH-1:0] g_data;
  logic                  beat;
  logic                  burst_full;

  // Round-robin search starting just after the last granted index.
  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    int cand;
    pick_vld = 1'b0;
    pick_idx = ptr_q;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = int'(ptr_q) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!pick_vld && bus.i_req_valid[IDX_W'(cand)]) begin
        pick_vld = 1'b1;
        pick_idx = IDX_W'(cand);
      end
    end
  end

  assign busy       = (state_q == S_BURST);
  assign g_valid    = bus.i_req_valid[gidx_q];
  assign g_last     = bus.i_req_last[gidx_q];
  assign g_data     = bus.i_req_data[int'(gidx_q)*DATA_WIDTH +: DATA_WIDTH];
  assign beat       = busy && g_valid && !bus.i_fifo_wfull;
  assign burst_full = (bcnt_q == BC_W'(MAX_BURST - 1));

  // Zero-latency steering: the granted lane drives the FIFO port directly.
  assign bus.o_fifo_wr    = beat;
  assign bus.o_fifo_wdata = busy ? g_data : '0;
  assign bus.o_req_ready  = (busy && !bus.i_fifo_wfull) ? grant_q : '0;
  assign bus.o_grant      = grant_q;
  assign bus.o_busy       = busy;

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge i_wclk or negedge i_rrstn) begin
    if (!i_rrstn) begin
      state_q <= S_IDLE;
      grant_q <= '0;
      gidx_q  <= '0;
      ptr_q   <= IDX_W'(NUM_REQ - 1);
      bcnt_q  <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (pick_vld) begin
            state_q <= S_BURST;
            grant_q <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick_idx;
            gidx_q  <= pick_idx;
            ptr_q   <= pick_idx;
            bcnt_q  <= '0;
          end
        end
        S_BURST: begin
          if (beat) begin
            // Last beat and burst limit coinciding is a single release.
            if (g_last || burst_full) begin
              state_q <= S_IDLE;
              grant_q <= '0;
            end else begin
              bcnt_q <= bcnt_q + 1'b1;
            end
          end else if (!g_valid) begin
            state_q <= S_IDLE;
            grant_q <= '0;
          end
        end
        default: begin
          state_q <= S_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

`ifdef FIFO_ARB_STATS_EN
  logic [CNT_WIDTH-1:0] stat_q [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_stat
    // NOTE: the counter array is reset explicitly; it is visible state, not scratch storage.
    always_ff @(posedge i_wclk or negedge i_rrstn) begin
      if (!i_rrstn) begin
        stat_q[k] <= '0;
      end else if (beat && (gidx_q == IDX_W'(k)) && (stat_q[k] != '1)) begin
        stat_q[k] <= stat_q[k] + 1'b1;
      end
    end
    assign o_beat_cnt[k*CNT_WIDTH +: CNT_WIDTH] = stat_q[k];
  end
`else
  localparam int unused_cnt_width = CNT_WIDTH;
`endif

endmodule
